// File: rtl/addsub23_rr_scheduler.sv
// addsub23_rr_scheduler
//   Shares one 23-bit carry-select add/subtract datapath between N_REQ
//   requesters. Requesters are granted round-robin. Each accepted request
//   runs through a three-state FSM: IDLE (grant and capture), EXEC (compute)
//   and RESP (hold the result until the consumer takes it).
//
// Ports
//   clk, rst     : clock; synchronous active-high reset
//   req_valid    : per-requester request valid             [N_REQ]
//   req_ready    : per-requester grant, one-hot or zero      [N_REQ]
//   req_a, req_b : packed operands, requester i at [23*i +: 23]
//   req_sub      : per-requester select, 1 = A-B, 0 = A+B    [N_REQ]
//   rsp_valid    : result valid (output)
//   rsp_ready    : consumer accepts the result (input)
//   rsp_sum      : 23-bit result
//   rsp_carry    : raw adder carry out (for A-B: 1 = no borrow)
//   rsp_id       : index of the requester that owns the result
//   rsp_ovf      : signed overflow flag, present only with ADDSUB23_OVF_FLAG_EN
//   busy         : FSM is not in IDLE
//
// Build option
//   ADDSUB23_OVF_FLAG_EN : adds the registered rsp_ovf output.

module addsub23_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [23*N_REQ-1:0]  req_a,
  input  logic [23*N_REQ-1:0]  req_b,
  input  logic [N_REQ-1:0]     req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [22:0]          rsp_sum,
  output logic                 rsp_carry,
  output logic [ID_W-1:0]      rsp_id,
`ifdef ADDSUB23_OVF_FLAG_EN
  output logic                 rsp_ovf,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [22:0]     a_q, a_d;
  logic [22:0]     b_q, b_d;
  logic            sub_q, sub_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [22:0]     rsp_sum_q, rsp_sum_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
`ifdef ADDSUB23_OVF_FLAG_EN
  logic            rsp_ovf_q, rsp_ovf_d;
`endif

  // Unpacked per-requester operand views
  logic [22:0] a_arr [N_REQ];
  logic [22:0] b_arr [N_REQ];

  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      a_arr[k] = req_a[23*k +: 23];
      b_arr[k] = req_b[23*k +: 23];
    end
  end

  // Round-robin search: first valid requester at or above the pointer,
  // wrapping modulo N_REQ. cand carries one extra bit so the wrap can be
  // done by a single conditional subtract for non-power-of-two N_REQ.
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Carry-select adder: the low 12 bits ripple with sub as carry-in; the
  // high 11 bits are computed for both carry-in values and selected by the
  // low-half carry.
  logic [22:0] b_eff;
  logic [11:0] lo_sum;
  logic        lo_c;
  logic [10:0] hi_sum0, hi_sum1;
  logic        hi_c0, hi_c1;
  logic [22:0] add_sum;
  logic        add_carry;

  always_comb begin
    b_eff              = b_q ^ {23{sub_q}};
    {lo_c, lo_sum}     = {1'b0, a_q[11:0]} + {1'b0, b_eff[11:0]} + {12'd0, sub_q};
    {hi_c0, hi_sum0}   = {1'b0, a_q[22:12]} + {1'b0, b_eff[22:12]};
    {hi_c1, hi_sum1}   = {1'b0, a_q[22:12]} + {1'b0, b_eff[22:12]} + 12'd1;
    add_sum            = {(lo_c ? hi_sum1 : hi_sum0), lo_sum};
    add_carry          = lo_c ? hi_c1 : hi_c0;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_id_d    = rsp_id_q;
`ifdef ADDSUB23_OVF_FLAG_EN
    rsp_ovf_d   = rsp_ovf_q;
`endif
    req_ready   = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          // grant_found already implies req_valid, so the grant is the handshake
          req_ready[grant_idx] = 1'b1;
          a_d     = a_arr[grant_idx];
          b_d     = b_arr[grant_idx];
          sub_d   = req_sub[grant_idx];
          id_d    = grant_idx;
          ptr_d   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = add_sum;
        rsp_carry_d = add_carry;
        rsp_id_d    = id_q;
`ifdef ADDSUB23_OVF_FLAG_EN
        rsp_ovf_d   = (a_q[22] == b_eff[22]) && (add_sum[22] != a_q[22]);
`endif
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
`ifdef ADDSUB23_OVF_FLAG_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_id_q    <= rsp_id_d;
`ifdef ADDSUB23_OVF_FLAG_EN
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = rsp_id_q;
`ifdef ADDSUB23_OVF_FLAG_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif
  assign busy      = (state_q != IDLE);

  // No grant while a response is outstanding, and never more than one grant
  a_no_grant_busy: assert property (@(posedge clk) disable iff (rst)
    (state_q != IDLE) |-> (req_ready == '0));
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

endmodule

// File: tb/tb_addsub23_rr_scheduler.sv
// Self-checking bench for addsub23_rr_scheduler: directed cases followed by
// randomized traffic, checked against a behavioural model (round-robin pick
// over a pointer, arithmetic done with plain integer operators).
module tb_addsub23_rr_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready, req_sub;
  logic [23*NREQ-1:0]  req_a, req_b;
  logic                rsp_valid, rsp_ready, rsp_carry, busy;
  logic [22:0]         rsp_sum;
  logic [IDW-1:0]      rsp_id;
`ifdef ADDSUB23_OVF_FLAG_EN
  logic                rsp_ovf;
  logic                exp_ovf;
`endif

  int          tests = 0;
  int          fails = 0;
  int unsigned model_ptr;
  logic [22:0] exp_sum;
  logic        exp_carry;
  int          exp_id;

  addsub23_rr_scheduler #(.N_REQ(NREQ), .ID_W(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id),
`ifdef ADDSUB23_OVF_FLAG_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one << i;
  endfunction

  // Spec rule: first valid requester searching upward from ptr, wrapping.
  function automatic int pick(input int unsigned ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return int'((ptr + k) % NREQ);
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [22:0] a, input logic [22:0] b, input logic s);
    req_a[i*23 +: 23] = a;
    req_b[i*23 +: 23] = b;
    req_sub[i]        = s;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*23 +: 23] = ($urandom_range(0, 5) == 0) ? 23'h7FFFFF : 23'($urandom);
      req_b[i*23 +: 23] = ($urandom_range(0, 5) == 0) ? 23'h000001 : 23'($urandom);
      req_sub[i]        = 1'($urandom);
    end
    req_valid = NREQ'($urandom);
  endtask

  task automatic check_rsp(input string tag);
    check({tag, "_valid"}, 32'(rsp_valid), 1);
    check({tag, "_sum"},   32'(rsp_sum),   32'(exp_sum));
    check({tag, "_carry"}, 32'(rsp_carry), 32'(exp_carry));
    check({tag, "_id"},    32'(rsp_id),    32'(exp_id));
    check({tag, "_busy"},  32'(busy),      1);
    check({tag, "_ready"}, 32'(req_ready), 0);
`ifdef ADDSUB23_OVF_FLAG_EN
    check({tag, "_ovf"},   32'(rsp_ovf),   32'(exp_ovf));
`endif
  endtask

  // Entered just after a rising edge with the DUT in IDLE and at least one
  // request valid. Returns just after the edge that brings the DUT back to IDLE.
  task automatic transact(input int unsigned stall, input bit mid_rand,
                          input logic [NREQ-1:0] mid_valid, output int gid);
    logic [22:0] a, b;
    logic        s;
    logic [23:0] wide;
    int          r;
    @(negedge clk);
    gid = pick(model_ptr, req_valid);
    check("grant", 32'(req_ready), 32'(onehot(gid)));
    check("idle_busy", 32'(busy), 0);
    a = req_a[gid*23 +: 23];
    b = req_b[gid*23 +: 23];
    s = req_sub[gid];
    model_ptr = (gid + 1) % NREQ;
    exp_id    = gid;
    wide      = {1'b0, a} + {1'b0, b};
    exp_sum   = s ? (a - b) : wide[22:0];
    exp_carry = s ? (a >= b) : wide[23];
    r = s ? (int'(signed'(a)) - int'(signed'(b))) : (int'(signed'(a)) + int'(signed'(b)));
`ifdef ADDSUB23_OVF_FLAG_EN
    exp_ovf = (r > 4194303) || (r < -4194304);
`endif
    @(posedge clk); #1;
    rsp_ready = (stall == 0);
    if (mid_rand) randomize_inputs();
    else          req_valid = mid_valid;
    @(negedge clk);
    check("exec_busy",  32'(busy),      1);
    check("exec_rspv",  32'(rsp_valid), 0);
    check("exec_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_rsp("resp");
    for (int unsigned j = 0; j < stall; j++) begin
      @(posedge clk); #1;
      if (j == stall - 1) rsp_ready = 1'b1;
      @(negedge clk);
      check_rsp("hold");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int gid;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b1;
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rspv",  32'(rsp_valid), 0);
    check("rst_sum",   32'(rsp_sum),   0);
    check("rst_carry", 32'(rsp_carry), 0);
    check("rst_id",    32'(rsp_id),    0);
    check("rst_busy",  32'(busy),      0);
    @(posedge clk); #1;

    // Single add, subtract with and without borrow, full-width carry
    set_req(0, 23'h000005, 23'h000003, 1'b0); req_valid = 4'b0001;
    transact(0, 0, '0, gid);
    check("add_sum_lit", 32'(exp_sum), 32'h8);
    set_req(2, 23'h000003, 23'h000005, 1'b1); req_valid = 4'b0100;
    transact(0, 0, '0, gid);
    set_req(2, 23'h000005, 23'h000003, 1'b1); req_valid = 4'b0100;
    transact(0, 0, '0, gid);
    set_req(3, 23'h7FFFFF, 23'h000001, 1'b0); req_valid = 4'b1000;
    transact(0, 0, '0, gid);
`ifdef ADDSUB23_OVF_FLAG_EN
    set_req(3, 23'h3FFFFF, 23'h000001, 1'b0); req_valid = 4'b1000;
    transact(0, 0, '0, gid);
`endif

    // Fairness: all valid, grants 0,1,2,3,0 at 3-cycle spacing
    for (int i = 0; i < NREQ; i++) set_req(i, 23'(100 * (i + 1)), 23'(7 * i), 1'(i % 2));
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      transact(0, 0, 4'b1111, gid);
      check("fair_order", 32'(gid), 32'(order[i]));
    end

    // Backpressure with req1 waiting, then req1 granted right after retire
    req_valid = 4'b0100;
    transact(5, 0, 4'b0010, gid);
    transact(0, 0, '0, gid);
    check("bp_next_id", 32'(gid), 1);

    // Reset in EXEC: response dropped, pointer back to 0
    req_valid = 4'b0010;
    @(negedge clk);
    check("rm_grant", 32'(req_ready), 32'(onehot(1)));
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_ptr = 0;
    repeat (3) begin
      @(negedge clk);
      check("rm_rspv",  32'(rsp_valid), 0);
      check("rm_busy",  32'(busy),      0);
      check("rm_sum",   32'(rsp_sum),   0);
      check("rm_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
    end
    req_valid = 4'b1111;
    transact(0, 0, '0, gid);
    check("rm_ptr0", 32'(gid), 0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      randomize_inputs();
      if (req_valid == '0) begin
        @(negedge clk);
        check("none_ready", 32'(req_ready), 0);
        check("none_busy",  32'(busy),      0);
        @(posedge clk); #1;
      end else begin
        transact($urandom_range(0, 2), 1, '0, gid);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
